// File: rtl/jackal_rom_pkg.sv
// Shared ROM image map: region identifiers, region limits, the readback FSM
// state type and the address-to-region decode used by both the download and
// the readback paths.
package jackal_rom_pkg;

    localparam int unsigned NUM_REGIONS = 9;

    // One-hot region select, bit order ep1,ep2,ep3,mask1..4,prom1,prom2
    typedef logic [NUM_REGIONS-1:0] cs_t;

    typedef enum logic [3:0] {
        REG_EP1   = 4'd0,
        REG_EP2   = 4'd1,
        REG_EP3   = 4'd2,
        REG_MASK1 = 4'd3,
        REG_MASK2 = 4'd4,
        REG_MASK3 = 4'd5,
        REG_MASK4 = 4'd6,
        REG_PROM1 = 4'd7,
        REG_PROM2 = 4'd8,
        REG_NONE  = 4'd9
    } region_e;

    // Exclusive upper limits of each region; prom2 ends at the last image byte
    localparam int unsigned LIM_EP1   = 32'h0001_0000;
    localparam int unsigned LIM_EP2   = 32'h0001_8000;
    localparam int unsigned LIM_EP3   = 32'h0002_0000;
    localparam int unsigned LIM_MASK1 = 32'h0004_0000;
    localparam int unsigned LIM_MASK2 = 32'h0006_0000;
    localparam int unsigned LIM_MASK3 = 32'h0008_0000;
    localparam int unsigned LIM_MASK4 = 32'h000A_0000;
    localparam int unsigned LIM_PROM1 = 32'h000A_0100;

    // Highest valid ROM-image byte address
    localparam int unsigned ROM_LAST_ADDR = 32'h000A_01FF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } rb_state_e;

    // Map a byte address onto its ROM region; anything past last is REG_NONE
    function automatic region_e rom_region(input logic [31:0] addr,
                                           input logic [31:0] last);
        if (addr < LIM_EP1)        return REG_EP1;
        else if (addr < LIM_EP2)   return REG_EP2;
        else if (addr < LIM_EP3)   return REG_EP3;
        else if (addr < LIM_MASK1) return REG_MASK1;
        else if (addr < LIM_MASK2) return REG_MASK2;
        else if (addr < LIM_MASK3) return REG_MASK3;
        else if (addr < LIM_MASK4) return REG_MASK4;
        else if (addr < LIM_PROM1) return REG_PROM1;
        else if (addr <= last)     return REG_PROM2;
        else                       return REG_NONE;
    endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational ROM address decode: one-hot region select plus a valid flag.
// Shared between the download selector and the readback path.
module rom_region_decode
    import jackal_rom_pkg::*;
#(
    parameter int          ADDR_W    = 25,
    parameter int unsigned LAST_ADDR = ROM_LAST_ADDR
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [NUM_REGIONS-1:0] cs,
    output logic                   valid
);

    region_e region;

    // Decode the address and expand the region index to a one-hot select
    always_comb begin
        region = rom_region(32'(addr), LAST_ADDR);
        valid  = (region != REG_NONE);
        cs     = '0;
        if (valid) begin
            cs = cs_t'(1) << region;
        end
    end

endmodule

// File: rtl/rom_readback.sv
// ROM readback for HPS ioctl uploads: reads loaded ROM dprams back through
// port B, returns bytes on ioctl_din and keeps a per-session checksum and
// byte count.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no read pending, port-B address released
// ISSUE | address registered on rb_addr, latency counter loaded
// WAIT  | counting down remaining port-B read latency
// RESP  | q valid: byte muxed onto ioctl_din, counters updated
module rom_readback
    import jackal_rom_pkg::*;
#(
    parameter int          RD_LAT    = 1,
    parameter int          ADDR_W    = 25,
    parameter int unsigned LAST_ADDR = ROM_LAST_ADDR
) (
    input  logic                   CLK_DL,
    input  logic                   RESET_N,
    input  logic                   ioctl_upload,
    input  logic                   ioctl_download,
    input  logic                   ioctl_rd,
    input  logic [ADDR_W-1:0]      ioctl_addr,
    output logic [7:0]             ioctl_din,
    output logic                   ioctl_wait,
    output logic                   rb_active,
    output logic [ADDR_W-1:0]      rb_addr,
    output logic [NUM_REGIONS-1:0] rb_cs,
    input  logic [7:0]             q_ep1,
    input  logic [7:0]             q_ep2,
    input  logic [7:0]             q_ep3,
    input  logic [7:0]             q_mask1,
    input  logic [7:0]             q_mask2,
    input  logic [7:0]             q_mask3,
    input  logic [7:0]             q_mask4,
    input  logic [3:0]             q_prom1,
    input  logic [3:0]             q_prom2,
    output logic [15:0]            csum,
    output logic [ADDR_W-1:0]      byte_cnt,
    output logic                   proto_err
);

    // ISSUE already accounts for one latency cycle, so WAIT covers the rest
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    rb_state_e        state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             upload_q;
    cs_t              dec_cs;
    logic             dec_valid;
    logic             rb_valid;
    logic [7:0]       rd_data;
    logic [7:0]       din_q;
    logic             accept;
    logic             abort;
    logic             resp_fire;
    logic             upload_rise;
    logic             perr_set;

    rom_region_decode #(
        .ADDR_W    (ADDR_W),
        .LAST_ADDR (LAST_ADDR)
    ) u_decode (
        .addr  (ioctl_addr),
        .cs    (dec_cs),
        .valid (dec_valid)
    );

    assign accept      = (state_q == ST_IDLE) && ioctl_upload && !ioctl_download && ioctl_rd;
    // Losing the upload session or a download starting both take port B away
    assign abort       = (state_q != ST_IDLE) && (!ioctl_upload || ioctl_download);
    assign resp_fire   = (state_q == ST_RESP) && !abort;
    assign upload_rise = ioctl_upload && !upload_q;
    assign perr_set    = ioctl_rd && (ioctl_download || (state_q != ST_IDLE));

    // Wait rises combinationally with the accepted strobe, then follows state
    assign ioctl_wait = accept || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign rb_active  = (state_q != ST_IDLE) && !ioctl_download;
    assign ioctl_din  = resp_fire ? rd_data : din_q;

    // Next-state and latency counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (RD_LAT <= 1) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_d == 2'd0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // Read-data mux by the registered region select; PROMs are 4 bits wide
    always_comb begin
        rd_data = ({8{rb_cs[REG_EP1]}}   & q_ep1)
                | ({8{rb_cs[REG_EP2]}}   & q_ep2)
                | ({8{rb_cs[REG_EP3]}}   & q_ep3)
                | ({8{rb_cs[REG_MASK1]}} & q_mask1)
                | ({8{rb_cs[REG_MASK2]}} & q_mask2)
                | ({8{rb_cs[REG_MASK3]}} & q_mask3)
                | ({8{rb_cs[REG_MASK4]}} & q_mask4)
                | ({8{rb_cs[REG_PROM1]}} & {4'h0, q_prom1})
                | ({8{rb_cs[REG_PROM2]}} & {4'h0, q_prom2})
                | ({8{!rb_valid}}        & 8'hFF);
    end

    // FSM state and latency counter registers
    always_ff @(posedge CLK_DL or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request address and its decoded region when accepted
    always_ff @(posedge CLK_DL or negedge RESET_N) begin
        if (!RESET_N) begin
            rb_addr  <= '0;
            rb_cs    <= '0;
            rb_valid <= 1'b0;
        end else if (accept) begin
            rb_addr  <= ioctl_addr;
            rb_cs    <= dec_cs;
            rb_valid <= dec_valid;
        end
    end

    // Returned byte is held between responses
    always_ff @(posedge CLK_DL or negedge RESET_N) begin
        if (!RESET_N) begin
            din_q <= 8'h00;
        end else if (resp_fire) begin
            din_q <= rd_data;
        end
    end

    // Per-session checksum, byte count and protocol error flag
    always_ff @(posedge CLK_DL or negedge RESET_N) begin
        if (!RESET_N) begin
            upload_q  <= 1'b0;
            csum      <= 16'h0000;
            byte_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            upload_q <= ioctl_upload;
            if (upload_rise) begin
                csum      <= 16'h0000;
                byte_cnt  <= '0;
                proto_err <= 1'b0;
            end else if (resp_fire) begin
                csum <= csum + {8'h00, rd_data};
                if (byte_cnt != '1) begin
                    byte_cnt <= byte_cnt + ADDR_W'(1);
                end
            end
            if (perr_set) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_readback.sv
// Bench for rom_readback: two instances (port-B latency 1 and 3) share the
// ioctl stimulus; each gets its own delayed ROM model on port B.
module tb_rom_readback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upload = 1'b0;
    logic        download = 1'b0;
    logic        rd = 1'b0;
    logic [24:0] addr = '0;

    logic [7:0]  din   [2];
    logic        wt    [2];
    logic        act   [2];
    logic        perr  [2];
    logic [24:0] rba   [2];
    logic [24:0] bcnt  [2];
    logic [8:0]  cs    [2];
    logic [15:0] cks   [2];

    logic [7:0]  q_ep1 [2], q_ep2 [2], q_ep3 [2];
    logic [7:0]  q_m1 [2], q_m2 [2], q_m3 [2], q_m4 [2];
    logic [3:0]  q_p1 [2], q_p2 [2];

    logic [24:0] qaddr [2];
    logic [24:0] pa = '0;
    logic [24:0] pb [3] = '{25'd0, 25'd0, 25'd0};

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_csum [2];
    logic [24:0] m_cnt  [2];
    logic        m_perr;

    always #5 clk = ~clk;

    // ROM image content: deterministic function of region and address
    function automatic logic [7:0] rom_byte(input int r, input logic [24:0] a);
        return (a[7:0] ^ a[15:8] ^ a[23:16]) + 8'(r * 29) + 8'h37;
    endfunction

    function automatic logic [3:0] rom_nib(input int r, input logic [24:0] a);
        logic [7:0] b;
        b = rom_byte(r, a);
        return b[3:0];
    endfunction

    function automatic int region_of(input logic [24:0] a);
        int lim [9] = '{'h10000, 'h18000, 'h20000, 'h40000, 'h60000,
                        'h80000, 'hA0000, 'hA0100, 'hA0200};
        for (int i = 0; i < 9; i++) begin
            if (int'(a) < lim[i]) return i;
        end
        return 9;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [24:0] a);
        int r;
        r = region_of(a);
        if (r == 9) return 8'hFF;
        if (r >= 7) return {4'h0, rom_nib(r, a)};
        return rom_byte(r, a);
    endfunction

    function automatic logic [8:0] exp_cs(input logic [24:0] a);
        int r;
        r = region_of(a);
        if (r == 9) return 9'h000;
        return 9'h001 << r;
    endfunction

    // Port-B read pipelines: latency 1 for instance 0, latency 3 for instance 1
    always @(posedge clk) begin
        pa    <= rba[0];
        pb[0] <= rba[1];
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign qaddr[0] = pa;
    assign qaddr[1] = pb[2];

    for (genvar g = 0; g < 2; g++) begin : g_rom
        assign q_ep1[g] = rom_byte(0, qaddr[g]);
        assign q_ep2[g] = rom_byte(1, qaddr[g]);
        assign q_ep3[g] = rom_byte(2, qaddr[g]);
        assign q_m1[g]  = rom_byte(3, qaddr[g]);
        assign q_m2[g]  = rom_byte(4, qaddr[g]);
        assign q_m3[g]  = rom_byte(5, qaddr[g]);
        assign q_m4[g]  = rom_byte(6, qaddr[g]);
        assign q_p1[g]  = rom_nib(7, qaddr[g]);
        assign q_p2[g]  = rom_nib(8, qaddr[g]);
    end

    rom_readback #(.RD_LAT(1), .ADDR_W(25), .LAST_ADDR(32'hA01FF)) dut_l1 (
        .CLK_DL(clk), .RESET_N(rst_n), .ioctl_upload(upload), .ioctl_download(download),
        .ioctl_rd(rd), .ioctl_addr(addr), .ioctl_din(din[0]), .ioctl_wait(wt[0]),
        .rb_active(act[0]), .rb_addr(rba[0]), .rb_cs(cs[0]),
        .q_ep1(q_ep1[0]), .q_ep2(q_ep2[0]), .q_ep3(q_ep3[0]),
        .q_mask1(q_m1[0]), .q_mask2(q_m2[0]), .q_mask3(q_m3[0]), .q_mask4(q_m4[0]),
        .q_prom1(q_p1[0]), .q_prom2(q_p2[0]),
        .csum(cks[0]), .byte_cnt(bcnt[0]), .proto_err(perr[0]));

    rom_readback #(.RD_LAT(3), .ADDR_W(25), .LAST_ADDR(32'hA01FF)) dut_l3 (
        .CLK_DL(clk), .RESET_N(rst_n), .ioctl_upload(upload), .ioctl_download(download),
        .ioctl_rd(rd), .ioctl_addr(addr), .ioctl_din(din[1]), .ioctl_wait(wt[1]),
        .rb_active(act[1]), .rb_addr(rba[1]), .rb_cs(cs[1]),
        .q_ep1(q_ep1[1]), .q_ep2(q_ep2[1]), .q_ep3(q_ep3[1]),
        .q_mask1(q_m1[1]), .q_mask2(q_m2[1]), .q_mask3(q_m3[1]), .q_mask4(q_m4[1]),
        .q_prom1(q_p1[1]), .q_prom2(q_p2[1]),
        .csum(cks[1]), .byte_cnt(bcnt[1]), .proto_err(perr[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_din"},   32'(din[i]),  32'h0);
            chk({tag, "_wait"},  32'(wt[i]),   32'h0);
            chk({tag, "_act"},   32'(act[i]),  32'h0);
            chk({tag, "_addr"},  32'(rba[i]),  32'h0);
            chk({tag, "_cs"},    32'(cs[i]),   32'h0);
            chk({tag, "_csum"},  32'(cks[i]),  32'h0);
            chk({tag, "_cnt"},   32'(bcnt[i]), 32'h0);
            chk({tag, "_perr"},  32'(perr[i]), 32'h0);
        end
    endtask

    task automatic chk_session(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_csum"}, 32'(cks[i]),  32'(m_csum[i]));
            chk({tag, "_cnt"},  32'(bcnt[i]), 32'(m_cnt[i]));
            chk({tag, "_perr"}, 32'(perr[i]), 32'(m_perr));
        end
    endtask

    // One upload read; dbl repeats the strobe (new address) one cycle later
    task automatic do_read(input logic [24:0] a, input bit dbl);
        logic [7:0] e;
        logic [8:0] ec;
        int         w [2];
        logic [7:0] d [2];
        bit         done [2];
        e  = exp_byte(a);
        ec = exp_cs(a);
        @(posedge clk); #1;
        rd = 1'b1;
        addr = a;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            w[i] = wt[i] ? 1 : 0;
            d[i] = 8'h00;
            done[i] = 1'b0;
        end
        for (int k = 0; k < 12 && !(done[0] && done[1]); k++) begin
            @(posedge clk); #1;
            rd = (dbl && k == 0);
            if (dbl && k == 0) addr = a ^ 25'h0A5A5;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!done[i]) begin
                    if (wt[i]) w[i]++;
                    else begin
                        done[i] = 1'b1;
                        d[i] = din[i];
                    end
                end
            end
        end
        rd = 1'b0;
        if (dbl) m_perr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("rd_done",   32'(done[i]), 32'h1);
            chk("wait_len",  32'(w[i]),    32'((i == 0 ? 1 : 3) + 1));
            chk("rd_din",    32'(d[i]),    32'(e));
            chk("rd_cs",     32'(cs[i]),   32'(ec));
            chk("rd_addr",   32'(rba[i]),  32'(a));
            m_csum[i] = m_csum[i] + {8'h00, e};
            m_cnt[i]  = m_cnt[i] + 25'd1;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("din_hold", 32'(din[i]), 32'(e));
            chk("act_idle", 32'(act[i]), 32'h0);
        end
        chk_session("after_rd");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] bnd [12];
        m_csum = '{16'h0, 16'h0};
        m_cnt  = '{25'h0, 25'h0};
        m_perr = 1'b0;

        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        upload = 1'b1;
        @(negedge clk);

        do_read(25'h00005, 1'b0);
        chk("first_csum", 32'(cks[0]), 32'h003C);
        do_read(25'hA0150, 1'b0);
        do_read(25'hA0200, 1'b0);

        bnd = '{25'h0FFFF, 25'h10000, 25'h17FFF, 25'h18000, 25'h1FFFF, 25'h20000,
                25'h9FFFF, 25'hA0000, 25'hA00FF, 25'hA0100, 25'hA01FF, 25'h1FFFFFF};
        for (int n = 0; n < 12; n++) do_read(bnd[n], 1'b0);

        for (int n = 0; n < 20; n++) do_read(25'($urandom_range(0, 'hA0400)), 1'b0);

        do_read(25'h2A5F0, 1'b1);

        // Upload dropped while the latency-3 instance is in WAIT
        @(posedge clk); #1;
        rd = 1'b1;
        addr = 25'h12345;
        @(posedge clk); #1;
        rd = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        upload = 1'b0;
        @(negedge clk);
        chk("abort_pre_wait", 32'(wt[1]), 32'h1);
        @(negedge clk);
        chk("abort_wait", 32'(wt[1]),  32'h0);
        chk("abort_act",  32'(act[1]), 32'h0);
        m_csum[0] = m_csum[0] + {8'h00, exp_byte(25'h12345)};
        m_cnt[0]  = m_cnt[0] + 25'd1;
        repeat (2) @(negedge clk);
        chk_session("abort");

        // Strobe with no upload session: ignored, flag untouched
        @(posedge clk); #1;
        rd = 1'b1;
        addr = 25'h00005;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("noup_wait", 32'(wt[i]), 32'h0);
        @(posedge clk); #1;
        rd = 1'b0;
        @(negedge clk);
        chk_session("noup");

        // Re-raising upload clears the session
        @(posedge clk); #1;
        upload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_csum = '{16'h0, 16'h0};
        m_cnt  = '{25'h0, 25'h0};
        m_perr = 1'b0;
        chk_session("reopen");

        // Upload low with flag clear: still no error raised
        @(posedge clk); #1;
        upload = 1'b0;
        rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        @(negedge clk);
        chk_session("noup_clean");
        @(posedge clk); #1;
        upload = 1'b1;
        @(negedge clk);

        // Strobe during download: no response, error flagged
        @(posedge clk); #1;
        download = 1'b1;
        rd = 1'b1;
        addr = 25'h00005;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("dl_wait", 32'(wt[i]),  32'h0);
            chk("dl_act",  32'(act[i]), 32'h0);
        end
        @(posedge clk); #1;
        rd = 1'b0;
        m_perr = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) chk("dl_act_late", 32'(act[i]), 32'h0);
        chk_session("download");
        @(posedge clk); #1;
        download = 1'b0;

        do_read(25'h33333, 1'b0);

        // Asynchronous reset in the middle of a read
        @(posedge clk); #1;
        rd = 1'b1;
        addr = 25'h30000;
        @(posedge clk); #1;
        rd = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_csum = '{16'h0, 16'h0};
        m_cnt  = '{25'h0, 25'h0};
        m_perr = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("post_rst_wait", 32'(wt[i]),  32'h0);
            chk("post_rst_act",  32'(act[i]), 32'h0);
        end

        do_read(25'h7ABCD, 1'b0);
        do_read(25'hA00A5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rom_readback.md
Name: rom_readback

Overview:
- Upload-direction counterpart of the ROM download path: services HPS ioctl upload read requests by reading the already-loaded ROM/PROM dprams back through their port B and returning bytes on ioctl_din.
- Used for load verification and dumping; also keeps a running 16-bit checksum and byte count per upload session.
- Sits in the CLK_DL domain beside the download selector; while active, it owns the port-B address of every ROM instance.

Parameters:
- RD_LAT, 1, dpram port-B read latency in cycles from address to q; legal values 1..3.
- ADDR_W, 25, ioctl address width.
- LAST_ADDR, 'hA01FF, highest valid ROM-image byte address.

Ports:
- CLK_DL  in  1  download/upload clock.
- RESET_N  in  1  asynchronous active-low reset.
- ioctl_upload  in  1  level; upload session active.
- ioctl_download  in  1  level; download in progress, which blocks readback.
- ioctl_rd  in  1  one-cycle read request strobe.
- ioctl_addr  in  ADDR_W  byte address of the request.
- ioctl_din  out  8  returned byte.
- ioctl_wait  out  1  high while a read is pending.
- rb_active  out  1  high while the block drives the port-B address; steers the port-B address mux.
- rb_addr  out  ADDR_W  registered address presented to all ROM port Bs.
- rb_cs  out  9  one-hot region select, order ep1,ep2,ep3,mask1..4,prom1,prom2.
- q_ep1, q_ep2, q_ep3, q_mask1, q_mask2, q_mask3, q_mask4  in  8 each  port-B read data.
- q_prom1, q_prom2  in  4 each  port-B read data, zero-extended to 8.
- csum  out  16  running byte sum (mod 2^16) for this session.
- byte_cnt  out  ADDR_W  bytes returned this session.
- proto_err  out  1  sticky flag: ioctl_rd arrived while busy, or arrived during download.

Behaviour:
- Reset: FSM=IDLE; ioctl_din=0, ioctl_wait=0, rb_active=0, rb_addr=0, rb_cs=0, csum=0, byte_cnt=0, proto_err=0.
- Region map is fixed:
  - ep1 <'h10000
  - ep2 <'h18000
  - ep3 <'h20000
  - mask1 <'h40000
  - mask2 <'h60000
  - mask3 <'h80000
  - mask4 <'hA0000
  - prom1 <'hA0100
  - prom2 <=LAST_ADDR
  - anything above LAST_ADDR is invalid: rb_cs=0 and the returned data is 'hFF.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On ioctl_upload=1, ioctl_download=0 and ioctl_rd=1: latch addr into rb_addr, latch the decoded rb_cs, set ioctl_wait=1 in the same cycle (combinational from the strobe, then registered), set rb_active=1, go to ISSUE.
- ISSUE:
  - Load the latency counter with RD_LAT-1, then go to WAIT, or straight to RESP if RD_LAT=1.
- WAIT:
  - Decrement the counter; at 0 go to RESP.
- RESP:
  - Mux q by the registered rb_cs into ioctl_din (PROMs zero-extended; invalid region gives 'hFF).
  - ioctl_wait=0, csum+=ioctl_din, byte_cnt+=1, then go to IDLE.
  - ioctl_din holds its value until the next RESP.
- Total latency from the ioctl_rd cycle to ioctl_wait falling is RD_LAT+1 cycles.
- rb_active stays high from ISSUE through RESP and drops in IDLE. It must be 0 whenever ioctl_download=1.
- ioctl_rd while not IDLE: ignored, proto_err<=1, and the in-flight read completes unchanged.
- ioctl_rd while ioctl_download=1 or ioctl_upload=0: ignored, no response; proto_err<=1 only if ioctl_download=1.
- ioctl_upload falls mid-read: abort to IDLE the next cycle. ioctl_wait=0, rb_active=0, and csum/byte_cnt are not updated for the aborted read.
- ioctl_upload rising edge (0->1): clear csum, byte_cnt and proto_err.
- Counters wrap: csum mod 2^16; byte_cnt saturates at all-ones.
- Async reset asserted mid-read: all outputs return to reset values immediately. No port-B access is outstanding after release.

Decomposition:
- Shared package jackal_rom_pkg holds:
  - the region enum (REG_EP1..REG_PROM2, REG_NONE)
  - the region base/limit constants
  - LAST_ADDR
  - a decode function returning the region.
- The existing download selector is later refactored to use the same function.
- One natural sub-module: rom_region_decode, combinational address to one-hot rb_cs plus a valid flag, shared by the download and readback paths.
- The FSM and data mux stay in rom_readback.

Test Plan:
- RD_LAT=1, upload=1, rd at addr 'h00005, q_ep1='h3C -> rb_cs=ep1, ioctl_wait high 2 cycles, ioctl_din='h3C, csum='h003C, byte_cnt=1.
- RD_LAT=3, rd at 'hA0150, q_prom2='hA -> rb_cs=prom2, wait high 4 cycles, ioctl_din='h0A.
- rd at 'hA0200 -> rb_cs=0, ioctl_din='hFF, csum+= 'hFF.
- Second ioctl_rd one cycle after the first -> ignored, proto_err=1, first read still returns correct data, byte_cnt=1.
- ioctl_upload dropped in WAIT (RD_LAT=3) -> next cycle IDLE, ioctl_wait=0, rb_active=0, csum/byte_cnt unchanged; re-raising upload clears all three.
- Sequential reads 'h0FFFF, 'h10000, 'h17FFF, 'h18000 -> rb_cs ep1, ep2, ep2, ep3 respectively; ioctl_download=1 during a request -> no response, proto_err=1, rb_active stays 0.
